// File: rtl/joystick_cmd_scheduler.sv
// joystick_cmd_scheduler
//   Turns debounced joystick levels into a serialized command stream over a
//   valid/ready handshake. Directions are resolved to a single code and
//   auto-repeated; fire is rate limited by a cooldown counter. One pending
//   bit per command type, drained by fixed priority FIRE > UP > DOWN > LEFT > RIGHT.
//
//   Build option: define JOY_FIRE_AUTO_EN to make the fire trigger the
//   i_fire level (auto-fire at the cooldown rate). Without it the trigger
//   is the rising edge of i_fire.
//
//   Direction FSM:
//     state    | meaning
//     ---------+--------------------------------------------------------------
//     S_IDLE   | no direction resolved, counter cleared
//     S_DELAY  | direction emitted, counting down to the first repeat
//     S_REPEAT | direction held past the first repeat, periodic repeats

module joystick_cmd_scheduler #(
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned FIRE_COOLDOWN = 2500000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_fire,
  input  logic       i_cmd_ready,
  output logic       o_cmd_valid,
  output logic [2:0] o_cmd,
  output logic [4:0] o_pending,
  output logic       o_drop
);

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_FIRE  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DLY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LOAD  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(FIRE_COOLDOWN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_latched;
  logic [2:0]       w_latched_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [2:0]       w_vert;
  logic [2:0]       w_horz;
  logic [2:0]       w_res;
  logic             w_dir_evt;
  logic [2:0]       w_dir_code;
  logic [3:0]       w_dir_set;

  logic [CNT_W-1:0] r_cool;
  logic             w_fire_trig;
  logic             w_fire_evt;

  logic [4:0]       r_pend;
  logic [4:0]       w_set;
  logic [4:0]       w_clr;
  logic [4:0]       w_clr_eff;
  logic [4:0]       w_pend_nxt;
  logic             w_drop_nxt;
  logic             r_drop;

  logic             r_valid;
  logic [2:0]       r_cmd;
  logic [2:0]       w_load_code;
  logic             w_slot_free;
  logic             w_load;

  // Resolve opposing and diagonal inputs: vertical wins over horizontal,
  // opposing pairs cancel.
  always_comb begin
    w_vert = CMD_NONE;
    w_horz = CMD_NONE;
    if (i_up & ~i_down) begin
      w_vert = CMD_UP;
    end else if (i_down & ~i_up) begin
      w_vert = CMD_DOWN;
    end
    if (i_left & ~i_right) begin
      w_horz = CMD_LEFT;
    end else if (i_right & ~i_left) begin
      w_horz = CMD_RIGHT;
    end
    w_res = (w_vert != CMD_NONE) ? w_vert : w_horz;
  end

  // Direction FSM state, latched direction and repeat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_latched <= CMD_NONE;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_latched <= w_latched_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Direction FSM next state and event generation.
  always_comb begin
    w_state_nxt   = r_state;
    w_latched_nxt = r_latched;
    w_cnt_nxt     = r_cnt;
    w_dir_evt     = 1'b0;
    w_dir_code    = CMD_NONE;
    case (r_state)
      S_IDLE: begin
        if (w_res != CMD_NONE) begin
          w_dir_evt     = 1'b1;
          w_dir_code    = w_res;
          w_latched_nxt = w_res;
          w_cnt_nxt     = DLY_LOAD;
          w_state_nxt   = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (w_res == CMD_NONE) begin
          w_state_nxt   = S_IDLE;
          w_latched_nxt = CMD_NONE;
          w_cnt_nxt     = '0;
        end else if (w_res != r_latched) begin
          // A new direction restarts the full delay, not the period.
          w_dir_evt     = 1'b1;
          w_dir_code    = w_res;
          w_latched_nxt = w_res;
          w_cnt_nxt     = DLY_LOAD;
          w_state_nxt   = S_DELAY;
        end else if (r_cnt == '0) begin
          w_dir_evt     = 1'b1;
          w_dir_code    = r_latched;
          w_cnt_nxt     = PER_LOAD;
          w_state_nxt   = S_REPEAT;
        end else begin
          w_cnt_nxt     = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_latched_nxt = CMD_NONE;
        w_cnt_nxt     = '0;
      end
    endcase
  end

  // Map a direction event to its pending bit {right,left,down,up}.
  always_comb begin
    w_dir_set = 4'b0000;
    if (w_dir_evt) begin
      case (w_dir_code)
        CMD_UP:    w_dir_set = 4'b0001;
        CMD_DOWN:  w_dir_set = 4'b0010;
        CMD_LEFT:  w_dir_set = 4'b0100;
        CMD_RIGHT: w_dir_set = 4'b1000;
        default:   w_dir_set = 4'b0000;
      endcase
    end
  end

`ifdef JOY_FIRE_AUTO_EN
  assign w_fire_trig = i_fire;
`else
  logic r_fire_q;

  // Previous fire level, used to detect the press edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fire_q <= 1'b0;
    end else begin
      r_fire_q <= i_fire;
    end
  end

  assign w_fire_trig = i_fire & ~r_fire_q;
`endif

  // Triggers during cooldown are discarded outright, never pended.
  assign w_fire_evt = w_fire_trig & (r_cool == '0);

  // Fire cooldown: load on an accepted fire event, then count down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cool <= '0;
    end else if (w_fire_evt) begin
      r_cool <= COOL_LOAD;
    end else if (r_cool != '0) begin
      r_cool <= r_cool - CNT_ONE;
    end
  end

  // Fixed-priority selection of the next command from the pending vector.
  always_comb begin
    w_load_code = CMD_NONE;
    w_clr       = 5'b00000;
    if (r_pend[4]) begin
      w_load_code = CMD_FIRE;
      w_clr       = 5'b10000;
    end else if (r_pend[0]) begin
      w_load_code = CMD_UP;
      w_clr       = 5'b00001;
    end else if (r_pend[1]) begin
      w_load_code = CMD_DOWN;
      w_clr       = 5'b00010;
    end else if (r_pend[2]) begin
      w_load_code = CMD_LEFT;
      w_clr       = 5'b00100;
    end else if (r_pend[3]) begin
      w_load_code = CMD_RIGHT;
      w_clr       = 5'b01000;
    end
  end

  assign w_slot_free = ~r_valid | i_cmd_ready;
  assign w_load      = w_slot_free & (r_pend != 5'b00000);
  assign w_clr_eff   = w_load ? w_clr : 5'b00000;
  assign w_set       = {w_fire_evt, w_dir_set};
  // Set wins over a same-cycle clear, so a bit being drained is not a drop.
  assign w_pend_nxt  = (r_pend & ~w_clr_eff) | w_set;
  assign w_drop_nxt  = |(w_set & r_pend & ~w_clr_eff);

  // Pending vector and coalesce pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 5'b00000;
      r_drop <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_drop <= w_drop_nxt;
    end
  end

  // Output slot: reload only when empty or being consumed, so o_cmd stays
  // stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_cmd   <= CMD_NONE;
    end else if (w_slot_free) begin
      r_valid <= w_load;
      r_cmd   <= w_load_code;
    end
  end

  assign o_cmd_valid = r_valid;
  assign o_cmd       = r_cmd;
  assign o_pending   = r_pend;
  assign o_drop      = r_drop;

endmodule
